adder_bcd_display: RTL and testbench
====================================

Name: adder_bcd_display

Overview:
- Parametrised successor to the 2-bit adder plus single seven-segment path.
- Registers an N-bit sum with carry-in, then converts it to BCD with an iterative double-dabble state machine.
- Drives a time-multiplexed DIGITS-wide seven-segment display.
- Sits between operand switches/registers and the board's shared-segment, per-digit-anode display.

Parameters:
- WIDTH, 8: operand width in bits; sum is WIDTH+1 bits.
- DIGITS, 3: number of decimal digits displayed (1..8).
- REFRESH_DIV, 50000: clock cycles each digit stays enabled before the scan advances (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c_in  input  1  carry-in.
- start  input  1  capture request, sampled only in IDLE.
- busy  output  1  high while converting.
- done  output  1  one-cycle pulse when the display registers update.
- sum  output  WIDTH+1  registered a+b+c_in; MSB is carry-out.
- ovf  output  1  registered; sum >= 10**DIGITS.
- seg  output  7  active-low segments; seg[0]=a through seg[6]=g.
- an  output  DIGITS  active-low digit enables; an[0] is the least-significant digit.

Behaviour:
- One clock. Reset is synchronous and active-high on rst, clocked by clk.
- Reset values:
  - sum=0, busy=0, done=0, ovf=0.
  - All display digit registers=0.
  - Scan index=0, scan counter=0.
  - an has only bit 0 low; seg=7'b1000000 (digit "0").
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - On start=1, register sum <= a+b+c_in in full WIDTH+1 bits (no truncation).
  - Register ovf from the same value.
  - Load the shift register, clear BCD scratch, go to CONVERT.
  - start=0 keeps the state.
- CONVERT:
  - One double-dabble iteration per cycle: add 3 to each BCD nibble >=5, then shift left 1.
  - Exactly WIDTH+1 iterations, then go to DONE.
  - Scratch holds enough nibbles for 2**(WIDTH+1)-1. Only the low DIGITS nibbles are displayed.
- DONE:
  - done=1 for exactly this cycle.
  - Display digit registers load from scratch. ovf display mode is latched.
  - Next state is IDLE.
- Latency: start sampled at cycle 0; busy=1 in cycles 1..WIDTH+1; done=1 in cycle WIDTH+2; busy=0 in DONE.
- start while busy or in DONE is ignored; no queuing.
- Operand changes after capture have no effect.
- Display registers hold the previous result until DONE, so there is no partial-value flicker.
- ovf=1 display: every digit shows a dash, seg=7'b0111111 (g only).
- Scan:
  - Free-running counter counts 0..REFRESH_DIV-1.
  - On wrap, the scan index advances, wrapping from DIGITS-1 to 0.
  - an = ~(1<<index). seg is the decode of the selected digit, combinational from registers.
  - Scanning is independent of the FSM and continues during CONVERT.
- Decode table, seg[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble values 10..15 cannot occur; decode them as blank (1111111).
- rst mid-CONVERT: abort the conversion and return every register to its reset value in the next cycle. done is not asserted.

Optional Feature:
- Macro: LZ_BLANK_EN.
- Defined:
  - Leading-zero blanking. Any digit above the most-significant nonzero digit shows seg=7'b1111111.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - ovf dashes override blanking.
  - Reset display is "0" on digit 0 only.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Test Plan:
- Sum and BCD: WIDTH=8, DIGITS=3, REFRESH_DIV=4; a=200, b=55, c_in=1, start pulse.
  - Expect sum=256, busy cycles 1..9, done only in cycle 10, ovf=0.
  - Scanned segs: an[0]->0000010, an[1]->0010010, an[2]->0100100.
- Overflow: DIGITS=2; a=99, b=1, c_in=0 -> sum=100, ovf=1, both digits show 0111111.
- Ignored start: start again at cycle 3 with a=1, b=1 -> no effect; single done at cycle 10; sum stays 256; next IDLE start accepted.
- Reset mid-conversion: rst at cycle 5 -> cycle 6 shows busy=0, sum=0, an[0] low, seg=1000000; no done pulse.
- Scan wrap: REFRESH_DIV=4, DIGITS=3 -> an steps 110, 101, 011, 110 every 4 cycles; the sequence is unaffected by start.
- Blanking (LZ_BLANK_EN): a=7, b=0, c_in=0 -> digit0=1111000, digits 1 and 2 =1111111; without the macro, digits 1 and 2 =1000000.

Source files
------------

// File: rtl/adder_bcd_display.sv
// rtl/adder_bcd_display.sv - registered adder, iterative double-dabble BCD and multiplexed seven-segment scan
// Optional build macro: LZ_BLANK_EN (leading-zero blanking of the displayed digits).
module adder_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              c_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    sum,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  // Decimal digits needed for 2**(WIDTH+1)-1: floor((WIDTH+1)*log10(2))+1.
  localparam int BCD_N  = ((WIDTH + 1) * 30103) / 100000 + 1;
  localparam int SCR_N  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int SW     = 4 * SCR_N;
  localparam int ITER_W = $clog2(WIDTH + 2);
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] OVF_LIMIT = 64'(10 ** DIGITS);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t              state, state_next;
  logic [ITER_W-1:0]   iter;
  logic [WIDTH:0]      shreg;
  logic [SW-1:0]       scratch;
  logic [SW-1:0]       scr_adj;
  logic [SW+WIDTH:0]   dd_next;
  logic [WIDTH:0]      sum_calc;
  logic [3:0]          disp [DIGITS];
  logic                ovf_disp;
  logic [CNT_W-1:0]    scan_cnt;
  logic [IDX_W-1:0]    scan_idx;
  logic [3:0]          sel;

  assign sum_calc = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE:    if (start) state_next = S_CONVERT;
      S_CONVERT: begin
        busy = 1'b1;
        if (iter == ITER_W'(WIDTH)) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift the whole chain left
  always_comb begin
    scr_adj = scratch;
    for (int i = 0; i < SCR_N; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    dd_next = {scr_adj, shreg} << 1;
  end

  // Capture, conversion and display-register datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      ovf      <= 1'b0;
      shreg    <= '0;
      scratch  <= '0;
      iter     <= '0;
      ovf_disp <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sum     <= sum_calc;
          ovf     <= (64'(sum_calc) >= OVF_LIMIT);
          shreg   <= sum_calc;
          scratch <= '0;
          iter    <= '0;
        end
        S_CONVERT: begin
          scratch <= dd_next[SW+WIDTH:WIDTH+1];
          shreg   <= dd_next[WIDTH:0];
          iter    <= iter + ITER_W'(1);
        end
        S_DONE: begin
          for (int i = 0; i < DIGITS; i++) disp[i] <= scratch[4*i +: 4];
          ovf_disp <= ovf;
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

`ifdef LZ_BLANK_EN
  logic [IDX_W-1:0] msnz;
`endif

  // Select the scanned digit and decode it to active-low segments
  always_comb begin
    sel = 4'd0;
`ifdef LZ_BLANK_EN
    msnz = '0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) sel = disp[i];
`ifdef LZ_BLANK_EN
      if (disp[i] != 4'd0) msnz = IDX_W'(i);
`endif
    end
    case (sel)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
`ifdef LZ_BLANK_EN
    if (scan_idx > msnz) seg = SEG_BLANK;
`endif
    if (ovf_disp) seg = SEG_DASH;
    an = ~(DIGITS'(1) << scan_idx);
  end

endmodule

// File: tb/tb_adder_bcd_display.sv
// tb/tb_adder_bcd_display.sv - table-driven bench for adder_bcd_display (3-digit and 2-digit instances)
module tb_adder_bcd_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
`ifdef LZ_BLANK_EN
  localparam logic [6:0] BLANK = 7'b1111111;
`endif

  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            c;
    logic [8:0]      sum;
    logic            ovf3;
    logic            ovf2;
    logic [2:0][6:0] seg3;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, c_in;
  logic [7:0] a, b;
  logic       busy3, done3, ovf3, busy2, done2, ovf2;
  logic [8:0] sum3, sum2;
  logic [6:0] seg3, seg2;
  logic [2:0] an3;
  logic [1:0] an2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_bcd_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut3 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .start(start),
    .busy(busy3), .done(done3), .sum(sum3), .ovf(ovf3), .seg(seg3), .an(an3)
  );

  adder_bcd_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .start(start),
    .busy(busy2), .done(done2), .sum(sum2), .ovf(ovf2), .seg(seg2), .an(an2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int va, input int vb, input int vc, input int vs,
                              input logic o3, input logic o2,
                              input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
    vec_t v;
    v.a = 8'(va); v.b = 8'(vb); v.c = 1'(vc); v.sum = 9'(vs);
    v.ovf3 = o3; v.ovf2 = o2;
    v.seg3 = {d2, d1, d0};
    return v;
  endfunction

  function automatic logic [6:0] exp_seg(input vec_t v, input int i, input int ndig, input logic ov);
`ifdef LZ_BLANK_EN
    logic lead;
`endif
    if (ov) return DASH;
`ifdef LZ_BLANK_EN
    lead = (i > 0);
    for (int j = i; j < ndig; j++) if (v.seg3[j] != S0) lead = 1'b0;
    if (lead) return BLANK;
`endif
    return v.seg3[i];
  endfunction

  // Waits (bounded) until the requested digit is scanned; returns x on timeout.
  task automatic read_seg(input int ndig, input int i, output logic [6:0] s);
    logic [2:0] want;
    want = 3'(~(3'b001 << i));
    s = 7'bx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ndig == 3 && an3 == want) begin s = seg3; break; end
      if (ndig == 2 && an2 == want[1:0]) begin s = seg2; break; end
    end
  endtask

  // Cycle 0 = start asserted; bseen/dseen hold busy/done of the 3-digit DUT per cycle.
  task automatic run_conv(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                          input int restart_at, input int rst_at,
                          output logic [15:0] bseen, output logic [15:0] dseen);
    bseen = '0;
    dseen = '0;
    @(negedge clk);
    a = ta; b = tb2; c_in = tc; start = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      bseen[k] = busy3;
      dseen[k] = done3 | done2;
      if (k == rst_at + 1) begin
        check("rst_mid_busy", 32'(busy3), 32'd0);
        check("rst_mid_sum", 32'(sum3), 32'd0);
        check("rst_mid_an", 32'(an3), 32'b110);
        check("rst_mid_seg", 32'(seg3), 32'(S0));
        rst = 1'b0;
      end
      if (k == restart_at) begin
        start = 1'b1; a = 8'd1; b = 8'd1;
      end
      if (k == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [9];
    logic [15:0] bs, ds;
    logic [6:0]  s;
    logic [2:0]  scan_exp [4];

    vecs[0] = mk(200,  55, 1, 256, 1'b0, 1'b1, S2, S5, S6);
    vecs[1] = mk( 99,   1, 0, 100, 1'b0, 1'b1, S1, S0, S0);
    vecs[2] = mk(  7,   0, 0,   7, 1'b0, 1'b0, S0, S0, S7);
    vecs[3] = mk(255, 255, 1, 511, 1'b0, 1'b1, S5, S1, S1);
    vecs[4] = mk(  0,   0, 0,   0, 1'b0, 1'b0, S0, S0, S0);
    vecs[5] = mk( 50,  49, 0,  99, 1'b0, 1'b0, S0, S9, S9);
    vecs[6] = mk(128, 110, 1, 239, 1'b0, 1'b1, S2, S3, S9);
    vecs[7] = mk( 34,   8, 0,  42, 1'b0, 1'b0, S0, S4, S2);
    vecs[8] = mk( 60,   8, 0,  68, 1'b0, 1'b0, S0, S6, S8);
    scan_exp = '{3'b110, 3'b101, 3'b011, 3'b110};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    @(negedge clk);
    check("reset_sum", 32'(sum3), 32'd0);
    check("reset_busy", 32'(busy3), 32'd0);
    check("reset_done", 32'(done3), 32'd0);
    check("reset_ovf", 32'(ovf3), 32'd0);
    check("reset_an3", 32'(an3), 32'b110);
    check("reset_seg3", 32'(seg3), 32'(S0));
    check("reset_an2", 32'(an2), 32'b10);
    check("reset_seg2", 32'(seg2), 32'(S0));
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_conv(vecs[v].a, vecs[v].b, vecs[v].c, -1, -1, bs, ds);
      check($sformatf("v%0d_busy_window", v), 32'(bs), 32'h03FE);
      check($sformatf("v%0d_done_pulse", v), 32'(ds), 32'h0400);
      check($sformatf("v%0d_sum3", v), 32'(sum3), 32'(vecs[v].sum));
      check($sformatf("v%0d_sum2", v), 32'(sum2), 32'(vecs[v].sum));
      check($sformatf("v%0d_ovf3", v), 32'(ovf3), 32'(vecs[v].ovf3));
      check($sformatf("v%0d_ovf2", v), 32'(ovf2), 32'(vecs[v].ovf2));
      for (int i = 0; i < 3; i++) begin
        read_seg(3, i, s);
        check($sformatf("v%0d_seg3_d%0d", v, i), 32'(s), 32'(exp_seg(vecs[v], i, 3, vecs[v].ovf3)));
      end
      for (int i = 0; i < 2; i++) begin
        read_seg(2, i, s);
        check($sformatf("v%0d_seg2_d%0d", v, i), 32'(s), 32'(exp_seg(vecs[v], i, 2, vecs[v].ovf2)));
      end
    end

    // start during CONVERT is ignored, then a fresh start from IDLE is accepted
    run_conv(8'd200, 8'd55, 1'b1, 3, -1, bs, ds);
    check("ign_busy_window", 32'(bs), 32'h03FE);
    check("ign_done_pulse", 32'(ds), 32'h0400);
    check("ign_sum", 32'(sum3), 32'd256);
    run_conv(8'd1, 8'd1, 1'b0, -1, -1, bs, ds);
    check("next_done_pulse", 32'(ds), 32'h0400);
    check("next_sum", 32'(sum3), 32'd2);

    // reset asserted in cycle 5 of a conversion
    run_conv(8'd200, 8'd55, 1'b1, -1, 5, bs, ds);
    check("rst_busy_window", 32'(bs), 32'h003E);
    check("rst_no_done", 32'(ds), 32'h0000);
    check("rst_sum_after", 32'(sum3), 32'd0);
    read_seg(3, 0, s);
    check("rst_disp_d0", 32'(s), 32'(S0));

    // scan sequence from reset, with a start pulse in the middle
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("scan_c%0d", k), 32'(an3), 32'(scan_exp[k/4]));
      start = (k == 5);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
